// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the transmit and receive paths:
// frame state encoding, default word width and the parity helper.
package spi_pkg;

  localparam int SPI_MESSAGE_BITS = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spiTxState_t;

  // Even parity over a zero-extended word; extra zero bits do not change the result.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/spi_transmit_if.sv
// Load-side handshake into the SPI transmitter: the producer drives a word and
// its valid strobe, and the transmitter answers with ready.
interface spi_transmit_if
  import spi_pkg::*;
#(
  parameter int MESSAGE_BITS = SPI_MESSAGE_BITS
);

  logic [MESSAGE_BITS-1:0] loadData;
  logic                    loadValid;
  logic                    loadReady;

  modport master (output loadData, output loadValid, input loadReady);
  modport slave  (input loadData, input loadValid, output loadReady);

endinterface

// File: rtl/spi_tx_fifo.sv
// Word FIFO in front of the SPI shifter. Pointers wrap modulo DEPTH (a power of
// two); count spans 0..DEPTH so full and empty are distinct.
module spi_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spi_transmit.sv
// SPI slave transmitter: queues words and shifts them out MSB first while cs is high,
// back-to-back with no gap. Define SPI_TX_PARITY_EN to append an even-parity bit per frame.
module spi_transmit
  import spi_pkg::*;
#(
  parameter int                    MESSAGE_BITS = SPI_MESSAGE_BITS,
  parameter int                    FIFO_DEPTH   = 4,
  parameter logic [MESSAGE_BITS-1:0] IDLE_PATTERN = {MESSAGE_BITS{1'b0}}
) (
  input  logic                 spiClk,
  input  logic                 nRst,
  input  logic                 cs,
  spi_transmit_if.slave        bus,
  output logic                 sdo,
  output logic                 txDone,
  output logic                 underrun
);

  localparam int CNT_W = (MESSAGE_BITS > 1) ? $clog2(MESSAGE_BITS) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MESSAGE_BITS - 1);

  spiTxState_t             state_r;
  logic [MESSAGE_BITS-1:0] shift_r;
  logic [CNT_W-1:0]        bit_counter_r;
  logic [MESSAGE_BITS-1:0] fifo_rdata_s;
  logic [MESSAGE_BITS-1:0] next_word_s;
  logic [CW-1:0]           fifo_count_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    last_bit_s;
`ifdef SPI_TX_PARITY_EN
  logic                    parity_r;
  logic                    parity_phase_r;
`endif

  assign bus.loadReady = !fifo_full_s;
  assign push_s        = bus.loadValid && bus.loadReady;

`ifdef SPI_TX_PARITY_EN
  assign last_bit_s = parity_phase_r;
`else
  assign last_bit_s = (bit_counter_r == {CNT_W{1'b0}});
`endif

  spi_tx_fifo #(
    .WIDTH (MESSAGE_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (spiClk),
    .nRst  (nRst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (bus.loadData),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // A word is taken on frame start and immediately after the last bit while cs stays high.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cs) pop_s = 1'b1;
        else    pop_s = 1'b0;
      end
      SHIFT: begin
        if (cs && last_bit_s) pop_s = 1'b1;
        else                  pop_s = 1'b0;
      end
      default: pop_s = 1'b0;
    endcase
  end

  // Word presented to the shifter: FIFO head, or the idle pattern on underrun.
  always_comb begin
    next_word_s = IDLE_PATTERN;
    if (fifo_empty_s) next_word_s = IDLE_PATTERN;
    else              next_word_s = fifo_rdata_s;
  end

  // Frame FSM and shifter; sdo, txDone and underrun come straight from flops.
  always_ff @(posedge spiClk or negedge nRst) begin
    if (!nRst) begin
      state_r        <= IDLE;
      shift_r        <= {MESSAGE_BITS{1'b0}};
      bit_counter_r  <= LAST_IDX;
      sdo            <= 1'b0;
      txDone         <= 1'b0;
      underrun       <= 1'b0;
`ifdef SPI_TX_PARITY_EN
      parity_r       <= 1'b0;
      parity_phase_r <= 1'b0;
`endif
    end else if (pop_s) begin
      state_r       <= SHIFT;
      shift_r       <= next_word_s;
      bit_counter_r <= LAST_IDX;
      sdo           <= next_word_s[MESSAGE_BITS-1];
      underrun      <= underrun || (fifo_count_s == {CW{1'b0}});
`ifdef SPI_TX_PARITY_EN
      txDone         <= 1'b0;
      parity_r       <= even_parity(64'(next_word_s));
      parity_phase_r <= 1'b0;
`else
      txDone         <= (MESSAGE_BITS == 1);
`endif
    end else if ((state_r == SHIFT) && cs) begin
      state_r <= SHIFT;
`ifdef SPI_TX_PARITY_EN
      if (bit_counter_r == {CNT_W{1'b0}}) begin
        // Bit 0 has been driven; the parity bit closes the frame.
        parity_phase_r <= 1'b1;
        sdo            <= parity_r;
        txDone         <= 1'b1;
      end else begin
        bit_counter_r <= bit_counter_r - CNT_W'(1);
        sdo           <= shift_r[bit_counter_r - CNT_W'(1)];
        txDone        <= 1'b0;
      end
`else
      bit_counter_r <= bit_counter_r - CNT_W'(1);
      sdo           <= shift_r[bit_counter_r - CNT_W'(1)];
      txDone        <= (bit_counter_r == CNT_W'(1));
`endif
    end else begin
      // cs low: idle, or abandon a partial word without re-queuing it.
      state_r       <= IDLE;
      bit_counter_r <= LAST_IDX;
      sdo           <= 1'b0;
      txDone        <= 1'b0;
`ifdef SPI_TX_PARITY_EN
      parity_phase_r <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_spi_transmit.sv
// Scoreboard bench for spi_transmit: pushed words feed a model FIFO, frame starts
// expand them into expected {sdo, txDone} pairs compared on each falling edge.
module tb_spi_transmit;
  import spi_pkg::*;

  localparam int MB    = 8;
  localparam int DEPTH = 4;
`ifdef SPI_TX_PARITY_EN
  localparam int FB = MB + 1;
`else
  localparam int FB = MB;
`endif

  logic spiClk = 1'b0;
  logic nRst   = 1'b1;
  logic cs     = 1'b0;
  logic sdo;
  logic txDone;
  logic underrun;

  spi_transmit_if #(.MESSAGE_BITS(MB)) bus ();

  spi_transmit #(
    .MESSAGE_BITS (MB),
    .FIFO_DEPTH   (DEPTH),
    .IDLE_PATTERN (8'h00)
  ) dut (
    .spiClk   (spiClk),
    .nRst     (nRst),
    .cs       (cs),
    .bus      (bus.slave),
    .sdo      (sdo),
    .txDone   (txDone),
    .underrun (underrun)
  );

  always #5 spiClk = ~spiClk;

  logic [MB-1:0] word_q[$];
  logic [1:0]    exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic tick(output logic s, output logic d);
    @(posedge spiClk);
    @(negedge spiClk);
    s = sdo;
    d = txDone;
  endtask

  // Model frame start: take the next queued word (or zeros) and expand it.
  task automatic expect_frame();
    logic [MB-1:0] w;
    if (word_q.size() > 0) w = word_q.pop_front();
    else                   w = 8'h00;
    for (int i = MB - 1; i >= 0; i--) begin
`ifdef SPI_TX_PARITY_EN
      exp_q.push_back({w[i], 1'b0});
`else
      exp_q.push_back({w[i], (i == 0) ? 1'b1 : 1'b0});
`endif
    end
`ifdef SPI_TX_PARITY_EN
    exp_q.push_back({^w, 1'b1});
`endif
  endtask

  task automatic push_word(input logic [MB-1:0] w);
    logic exp_ready;
    exp_ready = (word_q.size() < DEPTH);
    bus.loadData  = w;
    bus.loadValid = 1'b1;
    n_checks++;
    if (bus.loadReady !== exp_ready)
      $display("FAIL push_ready(%h): loadReady=%b expected %b", w, bus.loadReady, exp_ready);
    else n_pass++;
    if (exp_ready) word_q.push_back(w);
    @(posedge spiClk);
    @(negedge spiClk);
    bus.loadValid = 1'b0;
  endtask

  task automatic test_reset();
    #2 nRst = 1'b0;
    #1;
    n_checks++; if (sdo !== 1'b0) $display("FAIL reset_sdo: got %b expected 0", sdo); else n_pass++;
    n_checks++; if (txDone !== 1'b0) $display("FAIL reset_txdone: got %b expected 0", txDone); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b expected 0", underrun); else n_pass++;
    n_checks++; if (bus.loadReady !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.loadReady); else n_pass++;
    @(negedge spiClk);
    nRst = 1'b1;
    @(negedge spiClk);
  endtask

  task automatic test_single_word();
    logic s, d;
    logic [1:0] e;
    push_word(8'hA5);
    cs = 1'b1;
    expect_frame();
    for (int i = 0; i < FB; i++) begin
      tick(s, d);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
      n_checks++;
      if ({s, d} !== e) $display("FAIL single_bit%0d: sdo,txDone=%b expected %b", i, {s, d}, e);
      else n_pass++;
    end
    cs = 1'b0;
    tick(s, d);
    n_checks++;
    if ({s, d} !== 2'b00) $display("FAIL single_idle: sdo,txDone=%b expected 00", {s, d}); else n_pass++;
    n_checks++;
    if (underrun !== 1'b0) $display("FAIL single_underrun: got %b expected 0", underrun); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic s, d;
    logic [1:0] e;
    int dones = 0;
    push_word(8'h3C);
    push_word(8'hFF);
    cs = 1'b1;
    expect_frame();
    expect_frame();
    for (int i = 0; i < 2 * FB; i++) begin
      tick(s, d);
      if (d === 1'b1) dones++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
      n_checks++;
      if ({s, d} !== e) $display("FAIL b2b_bit%0d: sdo,txDone=%b expected %b", i, {s, d}, e);
      else n_pass++;
    end
    cs = 1'b0;
    tick(s, d);
    n_checks++;
    if (dones !== 2) $display("FAIL b2b_done_count: got %0d expected 2", dones); else n_pass++;
  endtask

  task automatic test_fifo_full();
    logic s, d;
    logic [1:0] e;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    push_word(8'h55);
    n_checks++;
    if (bus.loadReady !== 1'b0) $display("FAIL full_ready: got %b expected 0", bus.loadReady); else n_pass++;
    cs = 1'b1;
    for (int f = 0; f < DEPTH; f++) expect_frame();
    for (int i = 0; i < DEPTH * FB; i++) begin
      tick(s, d);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
      n_checks++;
      if ({s, d} !== e) $display("FAIL full_bit%0d: sdo,txDone=%b expected %b", i, {s, d}, e);
      else n_pass++;
    end
    cs = 1'b0;
    tick(s, d);
    n_checks++;
    if (underrun !== 1'b0) $display("FAIL full_underrun: got %b expected 0", underrun); else n_pass++;
  endtask

  task automatic test_abort();
    logic s, d;
    logic [1:0] e;
    push_word(8'h81);
    push_word(8'h5A);
    cs = 1'b1;
    expect_frame();
    for (int i = 0; i < 3; i++) begin
      tick(s, d);
      e = exp_q.pop_front();
      n_checks++;
      if ({s, d} !== e) $display("FAIL abort_bit%0d: sdo,txDone=%b expected %b", i, {s, d}, e);
      else n_pass++;
    end
    exp_q.delete();
    cs = 1'b0;
    tick(s, d);
    n_checks++;
    if ({s, d} !== 2'b00) $display("FAIL abort_idle: sdo,txDone=%b expected 00", {s, d}); else n_pass++;
    cs = 1'b1;
    expect_frame();
    for (int i = 0; i < FB; i++) begin
      tick(s, d);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
      n_checks++;
      if ({s, d} !== e) $display("FAIL abort_next_bit%0d: sdo,txDone=%b expected %b", i, {s, d}, e);
      else n_pass++;
    end
    cs = 1'b0;
    tick(s, d);
  endtask

  task automatic test_word_07();
    logic s, d;
    logic [1:0] e;
    push_word(8'h07);
    cs = 1'b1;
    expect_frame();
    for (int i = 0; i < FB; i++) begin
      tick(s, d);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
      n_checks++;
      if ({s, d} !== e) $display("FAIL w07_bit%0d: sdo,txDone=%b expected %b", i, {s, d}, e);
      else n_pass++;
    end
    cs = 1'b0;
    tick(s, d);
  endtask

  task automatic test_push_pop_empty();
    logic s, d;
    logic [1:0] e;
    cs = 1'b1;
    bus.loadData  = 8'h66;
    bus.loadValid = 1'b1;
    n_checks++;
    if (bus.loadReady !== 1'b1) $display("FAIL ppe_ready: got %b expected 1", bus.loadReady); else n_pass++;
    expect_frame();
    word_q.push_back(8'h66);
    expect_frame();
    for (int i = 0; i < 2 * FB; i++) begin
      tick(s, d);
      if (i == 0) bus.loadValid = 1'b0;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
      n_checks++;
      if ({s, d} !== e) $display("FAIL ppe_bit%0d: sdo,txDone=%b expected %b", i, {s, d}, e);
      else n_pass++;
    end
    n_checks++;
    if (underrun !== 1'b1) $display("FAIL ppe_underrun: got %b expected 1", underrun); else n_pass++;
    cs = 1'b0;
    for (int i = 0; i < 5; i++) tick(s, d);
    n_checks++;
    if (underrun !== 1'b1) $display("FAIL underrun_sticky: got %b expected 1", underrun); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic s, d;
    logic [1:0] e;
    push_word(8'h11);
    push_word(8'h22);
    cs = 1'b1;
    expect_frame();
    tick(s, d);
    tick(s, d);
    nRst = 1'b0;
    #1;
    word_q.delete();
    exp_q.delete();
    n_checks++; if (sdo !== 1'b0) $display("FAIL rstmid_sdo: got %b expected 0", sdo); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL rstmid_underrun: got %b expected 0", underrun); else n_pass++;
    n_checks++; if (bus.loadReady !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", bus.loadReady); else n_pass++;
    cs = 1'b0;
    @(negedge spiClk);
    nRst = 1'b1;
    push_word(8'h33);
    cs = 1'b1;
    expect_frame();
    for (int i = 0; i < FB; i++) begin
      tick(s, d);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
      n_checks++;
      if ({s, d} !== e) $display("FAIL rstmid_bit%0d: sdo,txDone=%b expected %b", i, {s, d}, e);
      else n_pass++;
    end
    cs = 1'b0;
    tick(s, d);
    n_checks++;
    if (underrun !== 1'b0) $display("FAIL rstmid_after_underrun: got %b expected 0", underrun); else n_pass++;
  endtask

  initial begin
    bus.loadData  = 8'h00;
    bus.loadValid = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_fifo_full();
    test_abort();
    test_word_07();
    test_push_pop_empty();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_transmit.md
SPI_TRANSMIT -- requirements
Module: spi_transmit

Interface
REQ-001 Parameter MESSAGE_BITS, default 8, SHALL set the word width shifted per frame.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two, >=2), SHALL set the number of queued words.
REQ-003 Parameter IDLE_PATTERN, default 0, SHALL set the word sent when the FIFO is empty.
REQ-004 spiClk  input  1  SPI clock; all state SHALL update on its rising edge.
REQ-005 nRst  input  1  asynchronous, active-low reset.
REQ-006 cs  input  1  active-high frame select from the SPI master.
REQ-007 loadData  input  MESSAGE_BITS  word to queue for transmission.
REQ-008 loadValid  input  1  loadData is valid this cycle.
REQ-009 loadReady  output  1  the FIFO can accept a word this cycle.
REQ-010 sdo  output  1  serial data out, MSB first.
REQ-011 txDone  output  1  one-cycle pulse when the last bit of a word has been driven.
REQ-012 underrun  output  1  sticky flag: a word was needed while the FIFO was empty.

Function
REQ-013 A push SHALL occur on a rising edge where loadValid && loadReady.
REQ-014 loadReady SHALL equal !full, using the registered count, so a push is refused when full even if a pop occurs in the same cycle.
REQ-015 The FSM SHALL have exactly two states. IDLE: cs low, sdo=0. SHIFT: cs high, shifting.
REQ-016 IDLE->SHIFT SHALL occur on the first rising edge with cs=1. On that edge the module SHALL pop the FIFO head (or IDLE_PATTERN if empty), drive its MSB on sdo, and load bitCounter=MESSAGE_BITS-1.
REQ-017 In SHIFT, each rising edge SHALL decrement bitCounter and drive the next bit. The master samples sdo on the falling edge.
REQ-018 On the edge after the bit at bitCounter=0 is driven, with cs still 1, the module SHALL pop the next word with zero gap between frames (back-to-back frames).
REQ-019 txDone SHALL be high for the single cycle in which bit 0 (or the parity bit, per REQ-026) is on sdo.
REQ-020 A pop from an empty FIFO SHALL send IDLE_PATTERN and set underrun. underrun SHALL clear only on reset.
REQ-021 Simultaneous push and pop with an empty FIFO SHALL send IDLE_PATTERN, set underrun, and store the pushed word.
REQ-022 If cs falls mid-word, the FSM SHALL return to IDLE on the next edge and the partially sent word SHALL be discarded (not re-queued). txDone SHALL NOT pulse.
REQ-023 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH. The count SHALL be FIFO_DEPTH+1 values wide, with distinct full and empty.

Reset
REQ-024 When nRst is low, the module SHALL immediately force: state=IDLE, FIFO empty, sdo=0, txDone=0, underrun=0, loadReady=1, bitCounter=MESSAGE_BITS-1.
REQ-025 Reset mid-frame SHALL abort the frame and drop all queued words. Operation SHALL resume at the first rising edge after nRst rises.

Configuration
REQ-026 With macro SPI_TX_PARITY_EN defined, each frame SHALL be MESSAGE_BITS+1 bits, with an even-parity bit of the word driven after bit 0 and txDone on the parity cycle. Undefined, frames SHALL be exactly MESSAGE_BITS bits with no parity logic.

Structure
REQ-027 The shared package spi_pkg SHALL hold the state enum spiTxState_t (IDLE, SHIFT) and the default MESSAGE_BITS constant shared with the receive path.
REQ-028 The FIFO SHALL be a sub-module spi_tx_fifo (push/pop/full/empty/count, async active-low reset). The shifter and FSM SHALL reside in spi_transmit.

Verification
REQ-029 Push 0xA5, raise cs for 8 clocks -> sdo=1,0,1,0,0,1,0,1 on consecutive edges; txDone pulses on the 8th; underrun=0.
REQ-030 Push 0x3C,0xFF, hold cs for 16 clocks -> 00111100 then 11111111 with no gap; txDone pulses twice.
REQ-031 Push 5 words with cs low -> loadReady=0 after the 4th; the 5th is not stored; 4 frames then read back in order.
REQ-032 Raise cs with an empty FIFO -> 8 zero bits, underrun=1 held until nRst.
REQ-033 Drop cs after 3 bits of 0x81, then raise cs -> the next frame sends the next queued word; 0x81 is never completed; no txDone for it.
REQ-034 With SPI_TX_PARITY_EN defined, send 0x07 -> 9 bits 0,0,0,0,0,1,1,1,1; txDone on the 9th.
